// File: rtl/address_feeder_pkg.sv
// address_feeder_pkg: shared widths, depths, FSM encoding and range helper for the address feeder.
//   WORDINDEXBITS / LETTERINDEXBITS : index widths, ADDRBITS = their sum
//   MEMORYDEPTH                     : word indices >= this are out of range
//   DEFAULT_FIFODEPTH               : default input buffer depth (power of two, >= 2)
//   DROPCOUNTBITS                   : width of the saturating drop counter
package address_feeder_pkg;
    localparam int WORDINDEXBITS     = 8;
    localparam int LETTERINDEXBITS   = 4;
    localparam int ADDRBITS          = WORDINDEXBITS + LETTERINDEXBITS;
    localparam int MEMORYDEPTH       = 200;
    localparam int DEFAULT_FIFODEPTH = 8;
    localparam int DROPCOUNTBITS     = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, CLEAR} state_t;

    // Extra leading bit keeps the compare correct even when MEMORYDEPTH == 2**WORDINDEXBITS.
    function automatic logic in_range(input logic [ADDRBITS-1:0] a);
        return {1'b0, a[ADDRBITS-1 -: WORDINDEXBITS]} < (WORDINDEXBITS+1)'(MEMORYDEPTH);
    endfunction
endpackage

// File: rtl/address_feeder_if.sv
// address_feeder_if: bundle of the upstream handshake and storage-side signals of the feeder.
//   master : drives addressIn/addressValid/clearRequest/storageReady (upstream + storage side)
//   slave  : the feeder; drives addressReady, wordIndex, letterIndex, newAddress,
//            clearStorage, busy, droppedCount
interface address_feeder_if;
    import address_feeder_pkg::*;
    logic [ADDRBITS-1:0]        addressIn;
    logic                       addressValid;
    logic                       addressReady;
    logic                       clearRequest;
    logic                       storageReady;
    logic [WORDINDEXBITS-1:0]   wordIndex;
    logic [LETTERINDEXBITS-1:0] letterIndex;
    logic                       newAddress;
    logic                       clearStorage;
    logic                       busy;
    logic [DROPCOUNTBITS-1:0]   droppedCount;

    modport master (
        output addressIn, addressValid, clearRequest, storageReady,
        input  addressReady, wordIndex, letterIndex, newAddress, clearStorage, busy, droppedCount
    );
    modport slave (
        input  addressIn, addressValid, clearRequest, storageReady,
        output addressReady, wordIndex, letterIndex, newAddress, clearStorage, busy, droppedCount
    );
endinterface

// File: rtl/address_fifo.sv
// address_fifo: synchronous FIFO with flush.
//   clock, reset (async, active-high), push, pop, flush, din -> dout (head), full, empty
//   Caller guarantees no push when full and no pop when empty; flush wins over push/pop.
module address_fifo
    import address_feeder_pkg::*;
#(
    parameter int WIDTH = ADDRBITS,
    parameter int DEPTH = DEFAULT_FIFODEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr;
    logic [AW:0]      rd;

    // Pointers carry one wrap bit: equal -> empty, only wrap bit differs -> full.
    assign empty = wr == rd;
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign dout  = mem[rd[AW-1:0]];

    always_ff @(posedge clock)
        if (push) mem[wr[AW-1:0]] <= din;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr <= '0;
            rd <= '0;
        end else if (flush) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
        end
endmodule

// File: rtl/address_feeder.sv
// address_feeder: buffers flat hit addresses and issues them to storage one per newAddress strobe.
//   clock, reset (async, active-high)
//   bus (address_feeder_if.slave): addressIn/addressValid/addressReady input handshake,
//     clearRequest, storageReady, wordIndex/letterIndex/newAddress to storage,
//     clearStorage strobe, busy, droppedCount (saturating count of out-of-range words)
//   Optional macro ADDRESS_DEDUP_EN: discard an address equal to the last buffered one.
module address_feeder
    import address_feeder_pkg::*;
#(
    parameter int FIFODEPTH = DEFAULT_FIFODEPTH
) (
    input  logic              clock,
    input  logic              reset,
    address_feeder_if.slave   bus
);
    state_t                     state;
    state_t                     next;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic                       full;
    logic                       empty;
    logic                       fire;
    logic                       in_rng;
    logic                       dup;
    logic                       strobe;
    logic [ADDRBITS-1:0]        head;
    logic [WORDINDEXBITS-1:0]   word;
    logic [LETTERINDEXBITS-1:0] letter;
    logic [DROPCOUNTBITS-1:0]   drops;

    // Ready is held low during reset and while the buffer is being flushed.
    assign bus.addressReady = !reset && !full && state != CLEAR;
    assign fire             = bus.addressValid && bus.addressReady;
    assign in_rng           = in_range(bus.addressIn);
    assign push             = fire && in_rng && !dup;

`ifdef ADDRESS_DEDUP_EN
    logic [ADDRBITS-1:0] last;
    logic                last_vld;

    assign dup = last_vld && last == bus.addressIn;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            last     <= '0;
            last_vld <= 1'b0;
        end else if (flush) begin
            last_vld <= 1'b0;
        end else if (push) begin
            last     <= bus.addressIn;
            last_vld <= 1'b1;
        end
`else
    assign dup = 1'b0;
`endif

    address_fifo #(.WIDTH(ADDRBITS), .DEPTH(FIFODEPTH)) fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.addressIn),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) drops <= '0;
        else if (fire && !in_rng && drops != '1) drops <= drops + 1'b1;

    // GAP after every issue gives storage its recovery cycle; clear is only taken from IDLE
    // so an in-flight strobe always completes first.
    always_comb begin
        pop   = state == ISSUE && bus.storageReady;
        flush = state == CLEAR;
        next  = state == IDLE  ? (bus.clearRequest ? CLEAR : empty ? IDLE : ISSUE) :
                state == ISSUE ? (bus.storageReady ? GAP : ISSUE) : IDLE;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state  <= IDLE;
            strobe <= 1'b0;
            word   <= '0;
            letter <= '0;
        end else begin
            state  <= next;
            strobe <= pop;
            if (pop) {word, letter} <= head;
        end

    assign bus.wordIndex    = word;
    assign bus.letterIndex  = letter;
    assign bus.newAddress   = strobe;
    assign bus.clearStorage = flush;
    assign bus.busy         = !empty || state != IDLE;
    assign bus.droppedCount = drops;
endmodule

// File: tb/tb_address_feeder.sv
// tb_address_feeder: directed self-checking bench for address_feeder.
module tb_address_feeder;
    logic clock;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    int   strobes;
    int   clears;
    int   gap_err;
    int   last_strobe;
    logic [11:0] got_q[$];
    int          cyc_q[$];

    address_feeder_if bus();

    address_feeder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock)
        if (!reset) begin
            if (bus.newAddress) begin
                if (last_strobe >= 0 && cyc - last_strobe < 3) gap_err = gap_err + 1;
                last_strobe = cyc;
                strobes = strobes + 1;
                got_q.push_back({bus.wordIndex, bus.letterIndex});
                cyc_q.push_back(cyc);
            end
            if (bus.clearStorage) clears = clears + 1;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] a, input int max_wait, output bit ok, output int acc);
        bus.addressIn = a;
        bus.addressValid = 1'b1;
        ok = 1'b0;
        acc = -1;
        for (int i = 0; i <= max_wait && !ok; i++) begin
            @(negedge clock);
            ok = bus.addressReady;
            if (ok) acc = cyc;
            @(posedge clock);
            #1;
        end
        bus.addressValid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!bus.busy) break;
        end
        check(tag, 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    bit   ok;
    int   acc;
    int   s0;
    int   c0;
    int   q0;
    int   n_ok;

    initial begin
        cyc = 0;
        strobes = 0;
        clears = 0;
        gap_err = 0;
        last_strobe = -1;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.addressIn = '0;
        bus.addressValid = 1'b0;
        bus.clearRequest = 1'b0;
        bus.storageReady = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(bus.addressReady), 32'd0);
        check("rst_new", 32'(bus.newAddress), 32'd0);
        check("rst_clr", 32'(bus.clearStorage), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drop", 32'(bus.droppedCount), 32'd0);
        check("rst_word", 32'(bus.wordIndex), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // 1: single address, strobe three cycles after the accept cycle
        bus.storageReady = 1'b1;
        s0 = strobes;
        q0 = got_q.size();
        push(12'h0A5, 4, ok, acc);
        check("t1_acc", 32'(ok), 32'd1);
        wait_idle("t1_idle", 20);
        check("t1_cnt", strobes - s0, 32'd1);
        check("t1_word", 32'(got_q[q0][11:4]), 32'h0A);
        check("t1_letter", 32'(got_q[q0][3:0]), 32'h5);
        check("t1_lat", cyc_q[q0] - acc, 32'd3);

        // 2: fill buffer while storage stalled, then drain in order
        bus.storageReady = 1'b0;
        s0 = strobes;
        q0 = got_q.size();
        n_ok = 0;
        for (int i = 0; i < 8; i++) begin
            push(12'h010 + 12'(i) * 12'h011, 0, ok, acc);
            n_ok += int'(ok);
        end
        check("t2_accepted", n_ok, 32'd8);
        @(negedge clock);
        check("t2_ready_full", 32'(bus.addressReady), 32'd0);
        @(posedge clock);
        #1;
        push(12'h098, 2, ok, acc);
        check("t2_ninth", 32'(ok), 32'd0);
        check("t2_stall", strobes - s0, 32'd0);
        bus.storageReady = 1'b1;
        wait_idle("t2_idle", 60);
        check("t2_cnt", strobes - s0, 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_order%0d", i), 32'(got_q[q0 + i]), 32'(12'h010 + 12'(i) * 12'h011));
        check("t2_gap", gap_err, 32'd0);

        // 3: out-of-range drop, boundary in-range word, saturation
        s0 = strobes;
        push(12'hC80, 2, ok, acc);
        repeat (6) @(posedge clock);
        #1;
        check("t3_nostrobe", strobes - s0, 32'd0);
        check("t3_drop1", 32'(bus.droppedCount), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        q0 = got_q.size();
        push(12'hC70, 2, ok, acc);
        wait_idle("t3_idle", 20);
        check("t3_edge_cnt", strobes - s0, 32'd1);
        check("t3_edge_word", 32'(got_q[q0]), 32'hC70);
        for (int i = 0; i < 261; i++) push(12'hC80, 2, ok, acc);
        check("t3_sat", 32'(bus.droppedCount), 32'hFF);

        // 4: clear with three buffered; in-flight strobe completes, rest discarded
        bus.storageReady = 1'b0;
        s0 = strobes;
        c0 = clears;
        q0 = got_q.size();
        push(12'h031, 2, ok, acc);
        push(12'h032, 2, ok, acc);
        push(12'h033, 2, ok, acc);
        bus.clearRequest = 1'b1;
        bus.storageReady = 1'b1;
        repeat (3) @(posedge clock);
        #1 bus.clearRequest = 1'b0;
        @(negedge clock);
        check("t4_clr_now", 32'(bus.clearStorage), 32'd1);
        check("t4_ready_clr", 32'(bus.addressReady), 32'd0);
        repeat (10) @(negedge clock);
        check("t4_cnt", strobes - s0, 32'd1);
        check("t4_word", 32'(got_q[q0]), 32'h031);
        check("t4_clears", clears - c0, 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        @(posedge clock);
        #1;

        // 5: reset while a strobe is on the bus
        bus.storageReady = 1'b0;
        push(12'h041, 2, ok, acc);
        push(12'h042, 2, ok, acc);
        bus.storageReady = 1'b1;
        @(posedge clock);
        #1 check("t5_pre_new", 32'(bus.newAddress), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t5_new", 32'(bus.newAddress), 32'd0);
        check("t5_clr", 32'(bus.clearStorage), 32'd0);
        check("t5_drop", 32'(bus.droppedCount), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        s0 = strobes;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (10) @(negedge clock);
        check("t5_lost", strobes - s0, 32'd0);
        @(posedge clock);
        #1;

        // 6: duplicate handling
        s0 = strobes;
        q0 = got_q.size();
        push(12'h123, 2, ok, acc);
        push(12'h123, 2, ok, acc);
        push(12'h124, 2, ok, acc);
        wait_idle("t6_idle", 40);
`ifdef ADDRESS_DEDUP_EN
        check("t6_cnt", strobes - s0, 32'd2);
`else
        check("t6_cnt", strobes - s0, 32'd3);
`endif
        check("t6_last", 32'(got_q[got_q.size() - 1]), 32'h124);
        check("t6_first", 32'(got_q[q0]), 32'h123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
